ws2812_rx: RTL and testbench
============================

# ws2812_rx

WS2812 serial-stream decoder that sits directly downstream of the LED strip driver in the LED messenger design. It recovers 24-bit GRB pixel words from the one-wire data line by measuring high-pulse widths, and tags each word with its position in the frame. It also detects the ≥50 µs latch gap to delimit frames. It serves as an on-chip loopback checker for the driver and as the receive front end for chained-strip experiments.

## Interface
- CLK_FREQ, 50_000_000: clk frequency in Hz.
- BIT_THRESH_NS, 600: high-pulse threshold in ns; wider pulses decode as '1'.
- RESET_US, 50: low time in µs that constitutes a latch/reset gap.
- Derived: THRESH_CYC = (CLK_FREQ/1_000_000)*BIT_THRESH_NS/1000, integer floor; RESET_CYC = (CLK_FREQ/1_000_000)*RESET_US.

- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  1  WS2812 data line, asynchronous to clk.
- pixel  out  24  last decoded word, GRB order, first received bit in [23].
- pixel_valid  out  1  one-cycle pulse; pixel and pixel_idx valid.
- pixel_idx  out  8  index of pixel within the current frame, 0-based, saturates at 255.
- frame_done  out  1  one-cycle pulse on a latch gap that ends a frame containing ≥1 bit.
- frame_len  out  8  pixels completed in the ended frame (saturating 255); valid with frame_done.
- frame_err  out  1  high with frame_done when the frame ended on a partial pixel (bit count ≠ 0).
- busy  out  1  high while state ≠ IDLE.

## Operation
- din passes through a 2-flop synchronizer (s1, s2). Edges are detected on s2 against its registered copy.
- FSM states:
  - IDLE: line low, no bits since last latch. Rising edge goes to HIGH.
  - HIGH: high_cnt counts cycles with s2=1, 16-bit saturating. On falling edge, decode the bit and go to LOW.
  - LOW: low_cnt counts cycles with s2=0. A rising edge goes to HIGH. When low_cnt reaches RESET_CYC, perform the latch and go to IDLE.
- Bit decode: bit = (high_cnt > THRESH_CYC). The bit is shifted into a 24-bit shift register MSB-first, and bit_cnt increments.
- On the 24th bit:
  - pixel ← assembled word, pixel_valid=1, pixel_idx ← pix_cnt.
  - Then pix_cnt increments (saturating 255) and bit_cnt ← 0.
- Latch:
  - frame_done=1, frame_len ← pix_cnt, frame_err ← (bit_cnt≠0).
  - Clear pix_cnt, bit_cnt and the shift register. Partial bits are discarded, never emitted.
- No frame_done is issued in IDLE: the line idling low produces no pulses.
- A high pulse of any length is never treated as a latch; it decodes as '1' when the line eventually falls.
- Reset values: all outputs 0, FSM IDLE, all counters and synchronizer flops 0. If din is high at reset release, this appears as a rising edge and the pulse is decoded normally.
- Reset asserted mid-frame aborts the frame silently: no pixel_valid and no frame_done for the partial data.

## Timing
- Synchronizer latency is 2 cycles. high_cnt equals the din high width in clk cycles exactly when din is clk-aligned.
- Decode cycle D: the cycle in which pixel_valid asserts. D is exactly 3 rising edges after the first edge that samples din=0 at the end of the 24th high pulse.
- pixel_valid, frame_done and frame_err are single-cycle pulses.
- pixel, pixel_idx, frame_len hold their value until the next update.
- frame_done asserts exactly RESET_CYC cycles after the last bit-decode cycle, provided din stays low.
- A low gap of RESET_CYC−1 cycles does not latch: the next bit continues the current frame.
- Throughput: one bit per high+low pulse. The minimum decodable pulse is 1 cycle high and 1 cycle low; there are no back-to-back restrictions.
- pixel_valid and frame_done never coincide; a latch is always ≥RESET_CYC cycles after a decode.

## Test plan
All scenarios use CLK_FREQ=10_000_000, giving THRESH_CYC=6 and RESET_CYC=500. '0' symbol = 4 high/8 low cycles; '1' symbol = 8 high/4 low cycles.

- Reset: rst=1 with din toggling → all outputs 0 and busy=0. Release rst with din low → no pulses for 2000 cycles.
- Single pixel: send 0x123456 then hold low 600 cycles → exactly one pixel_valid with pixel=0x123456, idx=0. frame_done exactly 500 cycles later with frame_len=1, frame_err=0.
- Multi-frame: frame of 0xFF0000, 0x00FF00, 0x0000FF → idx 0, 1, 2 and frame_len=3. A second frame of 0xA5A5A5 → idx=0 and frame_len=1.
- Threshold boundary: high widths of 6 and 7 cycles (low 6) across 24 bits alternating → 6 decodes as '0', 7 as '1', giving pixel=0x555555. A 499-cycle low gap mid-pixel does not latch.
- Partial frame: 10 bits then 600 cycles low → no pixel_valid; frame_done with frame_len=0, frame_err=1.
- Reset mid-pixel: 12 bits, pulse rst for 3 cycles, then send 0x00FF00 and latch → pixel=0x00FF00, idx=0, frame_len=1, frame_err=0, and no frame_done before the new pixel.

Source files
------------

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 one-wire stream decoder.
// Measures each high pulse to recover a bit and assembles 24-bit GRB words,
// MSB first. Each word is tagged with its position in the frame. A long low
// gap after at least one bit closes the frame, reporting its pixel count and
// whether it ended on a partial pixel.
`timescale 1ns/1ps
module ws2812_rx #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BIT_THRESH_NS = 600,
  parameter int RESET_US      = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic [23:0] pixel,
  output logic        pixel_valid,
  output logic [7:0]  pixel_idx,
  output logic        frame_done,
  output logic [7:0]  frame_len,
  output logic        frame_err,
  output logic        busy
);

  localparam int THRESH_CYC = (CLK_FREQ / 1_000_000) * BIT_THRESH_NS / 1000;
  localparam int RESET_CYC  = (CLK_FREQ / 1_000_000) * RESET_US;
  localparam int LW         = $clog2(RESET_CYC + 1);

  localparam logic [15:0]   THRESH_W = 16'(THRESH_CYC);
  localparam logic [LW-1:0] RESET_L  = LW'(RESET_CYC);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t        state;
  logic          s1, s2, s2_d;
  logic          rise, fall;
  logic [15:0]   high_cnt;
  logic [LW-1:0] low_cnt;
  logic [4:0]    bit_cnt;
  logic [7:0]    pix_cnt;
  // Bits received so far in the current word; the 24th bit is taken live.
  logic [22:0]   shreg;
  logic          bit_val;

  assign bit_val = (high_cnt > THRESH_W);
  assign busy    = (state != IDLE);

  // Two-flop synchronizer, then registered edge pulses so the FSM sees
  // each edge for exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s2_d <= s2;
      rise <= s2 & ~s2_d;
      fall <= ~s2 & s2_d;
    end
  end

  // Pulse-width decoder, word assembly and latch-gap detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      high_cnt    <= '0;
      low_cnt     <= '0;
      bit_cnt     <= '0;
      pix_cnt     <= '0;
      shreg       <= '0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      pixel_idx   <= '0;
      frame_done  <= 1'b0;
      frame_len   <= '0;
      frame_err   <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state    <= HIGH;
            high_cnt <= 16'd1;
          end
        end
        HIGH: begin
          if (fall) begin
            state   <= LOW;
            low_cnt <= LW'(1);
            shreg   <= {shreg[21:0], bit_val};
            if (bit_cnt == 5'd23) begin
              pixel       <= {shreg, bit_val};
              pixel_valid <= 1'b1;
              pixel_idx   <= pix_cnt;
              bit_cnt     <= '0;
              if (pix_cnt != 8'hFF) pix_cnt <= pix_cnt + 8'd1;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else if (high_cnt != 16'hFFFF) begin
            high_cnt <= high_cnt + 16'd1;
          end
        end
        LOW: begin
          if (low_cnt == RESET_L) begin
            // Latch: close the frame and drop any partial word. A rise that
            // lands on this same cycle opens the next frame.
            frame_done <= 1'b1;
            frame_len  <= pix_cnt;
            frame_err  <= (bit_cnt != 5'd0);
            pix_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            high_cnt   <= 16'd1;
            state      <= rise ? HIGH : IDLE;
          end else if (rise) begin
            state    <= HIGH;
            high_cnt <= 16'd1;
          end else begin
            low_cnt <= low_cnt + LW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed bench for ws2812_rx at 10 MHz (THRESH 6, RESET 500).
// Stimulus tasks describe the line as pulses; an event model derives the
// cycle of every pixel and frame event, and a per-cycle compare process
// checks the DUT against it.
`timescale 1ns/1ps
module tb_ws2812_rx;

  localparam int CLK_FREQ = 10_000_000;
  localparam int THRESH   = 6;
  localparam int RST_CYC  = 500;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic [23:0] pixel;
  logic        pixel_valid;
  logic [7:0]  pixel_idx;
  logic        frame_done;
  logic [7:0]  frame_len;
  logic        frame_err;
  logic        busy;

  ws2812_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BIT_THRESH_NS(600),
    .RESET_US(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .pixel(pixel),
    .pixel_valid(pixel_valid),
    .pixel_idx(pixel_idx),
    .frame_done(frame_done),
    .frame_len(frame_len),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Event model state
  bit          open_frame = 1'b0;
  int          nbits = 0;
  int          npix = 0;
  logic [23:0] word = '0;
  int          dprev = 0;
  int          last_fall = 0;
  logic [23:0] exp_pix [int];
  logic [7:0]  exp_idx [int];
  logic [7:0]  exp_len [int];
  logic        exp_err [int];

  // Values the held outputs must show
  logic [23:0] cur_pixel = '0;
  logic [7:0]  cur_idx = '0;
  logic [7:0]  cur_len = '0;

  // Observations for the literal checks
  int          pv_n = 0, fd_n = 0, pv_cyc = 0, fd_cyc = 0;
  logic [23:0] obs_pixel = '0;
  logic [7:0]  obs_idx = '0, obs_len = '0;
  logic        obs_err = 1'b0;
  logic        pv_e, fd_e, err_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sched_latch(input int t);
    exp_len[t] = 8'(npix);
    exp_err[t] = (nbits != 0);
    npix = 0;
    nbits = 0;
    word = '0;
    open_frame = 1'b0;
  endtask

  task automatic hold_low(input int n);
    int start;
    start = cyc;
    if (open_frame && (dprev + RST_CYC <= start + n)) sched_latch(dprev + RST_CYC);
    din = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One high pulse of w cycles followed by l low cycles.
  task automatic send_pulse(input int w, input int l);
    int r;
    bit b;
    r = cyc + 1;
    if (open_frame && (dprev + RST_CYC <= r + 3)) sched_latch(dprev + RST_CYC);
    b = (w > THRESH);
    word = {word[22:0], b};
    nbits++;
    open_frame = 1'b1;
    last_fall = r + w;
    dprev = r + w + 3;
    if (nbits == 24) begin
      exp_pix[dprev] = word;
      exp_idx[dprev] = 8'((npix > 255) ? 255 : npix);
      if (npix < 255) npix++;
      nbits = 0;
    end
    din = 1'b1;
    repeat (w) @(posedge clk);
    #1;
    hold_low(l);
  endtask

  task automatic send_bit(input bit b);
    if (b) send_pulse(8, 4);
    else   send_pulse(4, 8);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    open_frame = 1'b0;
    nbits = 0;
    npix = 0;
    word = '0;
    exp_pix.delete();
    exp_idx.delete();
    exp_len.delete();
    exp_err.delete();
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Per-cycle comparison of every output against the event model.
  always @(negedge clk) begin
    if (rst) begin
      cur_pixel = '0;
      cur_idx   = '0;
      cur_len   = '0;
      chk("rst_pixel", 32'(pixel), 32'h0);
      chk("rst_pixel_valid", 32'(pixel_valid), 32'h0);
      chk("rst_pixel_idx", 32'(pixel_idx), 32'h0);
      chk("rst_frame_done", 32'(frame_done), 32'h0);
      chk("rst_frame_len", 32'(frame_len), 32'h0);
      chk("rst_frame_err", 32'(frame_err), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
    end else begin
      pv_e  = exp_pix.exists(cyc);
      fd_e  = exp_len.exists(cyc);
      err_e = fd_e ? exp_err[cyc] : 1'b0;
      if (pv_e) begin
        cur_pixel = exp_pix[cyc];
        cur_idx   = exp_idx[cyc];
      end
      if (fd_e) cur_len = exp_len[cyc];
      chk("pixel_valid", 32'(pixel_valid), 32'(pv_e));
      chk("frame_done", 32'(frame_done), 32'(fd_e));
      chk("pixel", 32'(pixel), 32'(cur_pixel));
      chk("pixel_idx", 32'(pixel_idx), 32'(cur_idx));
      chk("frame_len", 32'(frame_len), 32'(cur_len));
      chk("frame_err", 32'(frame_err), 32'(err_e));
      if (pixel_valid) begin
        pv_n++;
        pv_cyc = cyc;
        obs_pixel = pixel;
        obs_idx = pixel_idx;
        $display("pixel idx=%0d value=%06h cycle=%0d", pixel_idx, pixel, cyc);
      end
      if (frame_done) begin
        fd_n++;
        fd_cyc = cyc;
        obs_len = frame_len;
        obs_err = frame_err;
        $display("frame len=%0d err=%0d cycle=%0d", frame_len, frame_err, cyc);
      end
    end
  end

  initial begin
    #(200_000 * 100);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pv0, fd0;

    // Reset with din toggling, then release with din low and idle.
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      din = i[0];
      @(posedge clk);
      #1;
    end
    chk("t1_busy_in_reset", 32'(busy), 32'h0);
    din = 1'b0;
    rst = 1'b0;
    repeat (2000) @(posedge clk);
    #1;
    chk("t1_no_pixels", 32'(pv_n), 32'd0);
    chk("t1_no_frames", 32'(fd_n), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'h0);

    // Single pixel.
    pv0 = pv_n; fd0 = fd_n;
    send_word(24'h123456);
    chk("t2_busy_after_word", 32'(busy), 32'h1);
    hold_low(600);
    chk("t2_pv_count", 32'(pv_n - pv0), 32'd1);
    chk("t2_pixel", 32'(obs_pixel), 32'h123456);
    chk("t2_idx", 32'(obs_idx), 32'd0);
    chk("t2_decode_latency", 32'(pv_cyc - last_fall), 32'd3);
    chk("t2_fd_count", 32'(fd_n - fd0), 32'd1);
    chk("t2_fd_delay", 32'(fd_cyc - pv_cyc), 32'd500);
    chk("t2_frame_len", 32'(obs_len), 32'd1);
    chk("t2_frame_err", 32'(obs_err), 32'd0);
    chk("t2_busy_after_latch", 32'(busy), 32'h0);

    // Multi-frame.
    pv0 = pv_n; fd0 = fd_n;
    send_word(24'hFF0000);
    send_word(24'h00FF00);
    send_word(24'h0000FF);
    hold_low(600);
    chk("t3_pv_count", 32'(pv_n - pv0), 32'd3);
    chk("t3_last_pixel", 32'(obs_pixel), 32'h0000FF);
    chk("t3_last_idx", 32'(obs_idx), 32'd2);
    chk("t3_frame_len", 32'(obs_len), 32'd3);
    send_word(24'hA5A5A5);
    hold_low(600);
    chk("t3b_pixel", 32'(obs_pixel), 32'hA5A5A5);
    chk("t3b_idx", 32'(obs_idx), 32'd0);
    chk("t3b_frame_len", 32'(obs_len), 32'd1);
    chk("t3_fd_count", 32'(fd_n - fd0), 32'd2);

    // Threshold boundary with a 499-cycle gap mid-pixel.
    pv0 = pv_n; fd0 = fd_n;
    for (int i = 0; i < 24; i++) send_pulse((i % 2) ? 7 : 6, (i == 11) ? 499 : 6);
    hold_low(600);
    chk("t4_pv_count", 32'(pv_n - pv0), 32'd1);
    chk("t4_pixel", 32'(obs_pixel), 32'h555555);
    chk("t4_fd_count", 32'(fd_n - fd0), 32'd1);
    chk("t4_frame_len", 32'(obs_len), 32'd1);
    chk("t4_frame_err", 32'(obs_err), 32'd0);

    // Partial frame.
    pv0 = pv_n; fd0 = fd_n;
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    hold_low(600);
    chk("t5_pv_count", 32'(pv_n - pv0), 32'd0);
    chk("t5_fd_count", 32'(fd_n - fd0), 32'd1);
    chk("t5_frame_len", 32'(obs_len), 32'd0);
    chk("t5_frame_err", 32'(obs_err), 32'd1);

    // Reset mid-pixel.
    pv0 = pv_n; fd0 = fd_n;
    for (int i = 0; i < 12; i++) send_bit(1'b1);
    chk("t6_busy_mid", 32'(busy), 32'h1);
    rst = 1'b1;
    #10;
    chk("t6_busy_async_rst", 32'(busy), 32'h0);
    do_reset(3);
    send_word(24'h00FF00);
    hold_low(600);
    chk("t6_pv_count", 32'(pv_n - pv0), 32'd1);
    chk("t6_pixel", 32'(obs_pixel), 32'h00FF00);
    chk("t6_idx", 32'(obs_idx), 32'd0);
    chk("t6_fd_count", 32'(fd_n - fd0), 32'd1);
    chk("t6_frame_len", 32'(obs_len), 32'd1);
    chk("t6_frame_err", 32'(obs_err), 32'd0);

    repeat (5) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
